heu_ctrl: RTL and testbench
===========================

// Module: heu_ctrl
// PURPOSE
//  Phase sequencer for the histogram-equalization unit (HEU) datapath.
//  Accepts one ROWS x COLS byte window from the IPGU, then steps the datapath: capture, histogram clear,
//  histogram accumulate, CDF scan and pixel remap. Presents the result to the RDN with a ready/ready handshake.
//  Control only: drives enables and indices; it touches no pixel data.
// PARAMETERS
//  ROWS      5    window rows
//  COLS      80   window columns
//  SEG_W     16   pixels histogrammed per cycle; COLS % SEG_W == 0
//  BINS      256  histogram/CDF bins (8-bit pixels)
// PORTS
//  clk             in   1                     clock, all state on rising edge
//  rst             in   1                     synchronous, active-high reset
//  ipgu_out_ready  in   1                     IPGU has a window on d
//  rdn_in_ready    in   1                     RDN will take q this cycle
//  in_ready        out  1                     controller can accept a window
//  out_ready       out  1                     q valid, waiting for RDN
//  load_en         out  1                     datapath registers d this cycle
//  hist_clr        out  1                     zero all histogram bins
//  hist_en         out  1                     accumulate segment (hist_row, hist_seg)
//  hist_row        out  $clog2(ROWS)          row being histogrammed
//  hist_seg        out  $clog2(COLS/SEG_W)    column segment; pixels [seg*SEG_W +: SEG_W]
//  cdf_en          out  1                     cdf[cdf_bin] = cdf[cdf_bin-1] + hist[cdf_bin]
//  cdf_bin         out  $clog2(BINS)          bin index for CDF scan
//  cdf_first       out  1                     cdf_bin==0 (no predecessor term)
//  map_en          out  1                     remap row map_row through CDF
//  map_row         out  $clog2(ROWS)          row being remapped
//  busy            out  1                     state != IDLE
// BEHAVIOUR
//  States: IDLE, CLEAR, HIST, CDF, MAP, DONE.
//   - One-hot or binary encoding is allowed.
//   - Each control output is a decode of the state and counters only.
//  Reset (rst=1 at an edge):
//   - State goes to IDLE and all counters clear to 0.
//   - in_ready=1; every other output = 0; all indices = 0.
//   - Reset mid-operation abandons the frame. No out_ready is produced for it.
//  IDLE:
//   - in_ready=1.
//   - Accept is ipgu_out_ready && in_ready sampled at an edge; that edge moves the state to CLEAR.
//   - load_en = in_ready && ipgu_out_ready (combinational), so d is captured on the accept edge.
//  CLEAR: 1 cycle; hist_clr=1; then HIST.
//  HIST: ROWS*COLS/SEG_W cycles (25 by default); hist_en=1.
//   - hist_seg increments each cycle; on wrap to 0, hist_row increments.
//   - Leaves for CDF after (ROWS-1, COLS/SEG_W-1).
//  CDF: BINS cycles; cdf_en=1.
//   - cdf_bin counts 0..BINS-1, with cdf_first=1 only at bin 0.
//   - After BINS-1, moves to MAP. The bin counter must not wrap into a second pass.
//  MAP: ROWS cycles; map_en=1; map_row counts 0..ROWS-1; then DONE.
//  DONE:
//   - out_ready=1.
//   - If rdn_in_ready=1 at an edge, go to IDLE. out_ready drops and in_ready rises on the same edge.
//   - rdn_in_ready already high on entry completes after exactly 1 DONE cycle.
//  Latency: accept edge k -> DONE entered (out_ready rises) at edge k+1+ROWS*COLS/SEG_W+BINS+ROWS.
//   - Default: k+287.
//  Ignored inputs:
//   - ipgu_out_ready outside IDLE (in_ready=0, no load_en).
//   - rdn_in_ready outside DONE.
//  Exclusivity:
//   - in_ready and out_ready are never both 1.
//   - At most one of hist_clr/hist_en/cdf_en/map_en is 1 in any cycle.
//  Back-to-back: a new window is accepted no earlier than the first IDLE cycle after the DONE handshake.
// TESTING
//  1. Reset: hold rst 2 cycles -> in_ready=1, busy=0, all enables/indices 0.
//  2. Single frame:
//     - Stimulus: ipgu_out_ready pulsed 1 cycle at edge k; rdn_in_ready=0.
//     - Response: load_en=1 at k; hist_clr only at k+1; hist_en cycles k+2..k+26;
//       cdf_en k+27..k+282 (cdf_bin 0..255); map_en k+283..k+287 (row 0..4); out_ready=1 from k+288 and held.
//  3. Release:
//     - Stimulus: out_ready held 10 cycles, then rdn_in_ready=1 for 1 cycle.
//     - Response: next edge gives out_ready=0 and in_ready=1.
//     - Variant: rdn_in_ready tied 1 -> out_ready high exactly 1 cycle.
//  4. Ignored request: ipgu_out_ready held 1 throughout the frame -> no extra load_en.
//     A second accept occurs on the first IDLE cycle after release.
//  5. Mid-frame reset: rst during CDF at cdf_bin=100 -> IDLE next edge; no out_ready; next frame runs full 287-cycle latency.
//  6. Index sweep:
//     - Check: the hist (row,seg) sequence covers all 25 pairs once, in order.
//     - Check: enable exclusivity and in_ready/out_ready exclusivity, asserted every cycle.

Source files
------------

// File: rtl/heu_ctrl.sv
// Phase sequencer for the histogram-equalization unit.
// Walks the datapath through capture, histogram clear, histogram accumulate,
// CDF scan and pixel remap, then holds the result until the RDN takes it.
// Control only: every output is a registered decode of state and counters,
// except load_en, which must capture d on the same edge as the accept.
module heu_ctrl #(
  parameter int ROWS  = 5,
  parameter int COLS  = 80,
  parameter int SEG_W = 16,
  parameter int BINS  = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ipgu_out_ready,
  input  logic                            rdn_in_ready,
  output logic                            in_ready,
  output logic                            out_ready,
  output logic                            load_en,
  output logic                            hist_clr,
  output logic                            hist_en,
  output logic [$clog2(ROWS)-1:0]         hist_row,
  output logic [$clog2(COLS/SEG_W)-1:0]   hist_seg,
  output logic                            cdf_en,
  output logic [$clog2(BINS)-1:0]         cdf_bin,
  output logic                            cdf_first,
  output logic                            map_en,
  output logic [$clog2(ROWS)-1:0]         map_row,
  output logic                            busy
);

  localparam int NSEG   = COLS / SEG_W;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int SEGI_W = $clog2(NSEG);
  localparam int BIN_W  = $clog2(BINS);

  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [SEGI_W-1:0] LAST_SEG = SEGI_W'(NSEG - 1);
  localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_HIST  = 3'd2,
    S_CDF   = 3'd3,
    S_MAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic [ROW_W-1:0]    r_row;
  logic [SEGI_W-1:0]   r_seg;
  logic [BIN_W-1:0]    r_bin;
  logic [ROW_W-1:0]    r_mrow;
  logic                r_in_ready;
  logic                r_out_ready;
  logic                r_hist_clr;
  logic                r_hist_en;
  logic                r_cdf_en;
  logic                r_cdf_first;
  logic                r_map_en;
  logic                r_busy;
  logic                w_accept;

  // Capture strobe is combinational so d is registered on the accept edge itself.
  assign w_accept  = r_in_ready & ipgu_out_ready;
  assign load_en   = w_accept;

  assign in_ready  = r_in_ready;
  assign out_ready = r_out_ready;
  assign hist_clr  = r_hist_clr;
  assign hist_en   = r_hist_en;
  assign hist_row  = r_row;
  assign hist_seg  = r_seg;
  assign cdf_en    = r_cdf_en;
  assign cdf_bin   = r_bin;
  assign cdf_first = r_cdf_first;
  assign map_en    = r_map_en;
  assign map_row   = r_mrow;
  assign busy      = r_busy;

  // Phase FSM; output flags are loaded from the state being entered so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_seg       <= '0;
      r_bin       <= '0;
      r_mrow      <= '0;
      r_in_ready  <= 1'b1;
      r_out_ready <= 1'b0;
      r_hist_clr  <= 1'b0;
      r_hist_en   <= 1'b0;
      r_cdf_en    <= 1'b0;
      r_cdf_first <= 1'b0;
      r_map_en    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_CLEAR;
            r_in_ready <= 1'b0;
            r_hist_clr <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_state    <= S_HIST;
          r_hist_clr <= 1'b0;
          r_hist_en  <= 1'b1;
          r_row      <= '0;
          r_seg      <= '0;
        end
        S_HIST: begin
          if (r_seg == LAST_SEG) begin
            r_seg <= '0;
            if (r_row == LAST_ROW) begin
              // Last segment of last row: hand over to the CDF scan at bin 0.
              r_row       <= '0;
              r_state     <= S_CDF;
              r_hist_en   <= 1'b0;
              r_cdf_en    <= 1'b1;
              r_cdf_first <= 1'b1;
              r_bin       <= '0;
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end else begin
            r_seg <= r_seg + SEGI_W'(1);
          end
        end
        S_CDF: begin
          r_cdf_first <= 1'b0;
          if (r_bin == LAST_BIN) begin
            // Single pass only: park the bin index at 0 and leave.
            r_bin    <= '0;
            r_state  <= S_MAP;
            r_cdf_en <= 1'b0;
            r_map_en <= 1'b1;
            r_mrow   <= '0;
          end else begin
            r_bin <= r_bin + BIN_W'(1);
          end
        end
        S_MAP: begin
          if (r_mrow == LAST_ROW) begin
            r_mrow      <= '0;
            r_state     <= S_DONE;
            r_map_en    <= 1'b0;
            r_out_ready <= 1'b1;
          end else begin
            r_mrow <= r_mrow + ROW_W'(1);
          end
        end
        S_DONE: begin
          if (rdn_in_ready) begin
            r_state     <= S_IDLE;
            r_out_ready <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean idle.
          r_state     <= S_IDLE;
          r_row       <= '0;
          r_seg       <= '0;
          r_bin       <= '0;
          r_mrow      <= '0;
          r_in_ready  <= 1'b1;
          r_out_ready <= 1'b0;
          r_hist_clr  <= 1'b0;
          r_hist_en   <= 1'b0;
          r_cdf_en    <= 1'b0;
          r_cdf_first <= 1'b0;
          r_map_en    <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heu_ctrl.sv
// Directed bench for heu_ctrl: a phase-timeline model (cycles since accept)
// is compared against every output each cycle, plus literal checks on latency,
// phase lengths, handshake release, ignored requests and mid-frame reset.
module tb_heu_ctrl;

  localparam int ROWS  = 5;
  localparam int COLS  = 80;
  localparam int SEG_W = 16;
  localparam int BINS  = 256;
  localparam int NSEG  = COLS / SEG_W;
  localparam int T_H0  = 2;
  localparam int T_C0  = T_H0 + ROWS * NSEG;
  localparam int T_M0  = T_C0 + BINS;
  localparam int T_D   = T_M0 + ROWS;

  logic clk = 1'b0;
  logic rst, ipgu_out_ready, rdn_in_ready;
  logic in_ready, out_ready, load_en, hist_clr, hist_en, cdf_en, cdf_first, map_en, busy;
  logic [$clog2(ROWS)-1:0]       hist_row, map_row;
  logic [$clog2(COLS/SEG_W)-1:0] hist_seg;
  logic [$clog2(BINS)-1:0]       cdf_bin;

  heu_ctrl #(.ROWS(ROWS), .COLS(COLS), .SEG_W(SEG_W), .BINS(BINS)) dut (
    .clk(clk), .rst(rst), .ipgu_out_ready(ipgu_out_ready), .rdn_in_ready(rdn_in_ready),
    .in_ready(in_ready), .out_ready(out_ready), .load_en(load_en), .hist_clr(hist_clr),
    .hist_en(hist_en), .hist_row(hist_row), .hist_seg(hist_seg), .cdf_en(cdf_en),
    .cdf_bin(cdf_bin), .cdf_first(cdf_first), .map_en(map_en), .map_row(map_row), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_t = 0 idle, 1.. cycles since accept, saturating at T_D (result held).
  int m_t = 0;
  bit m_valid = 1'b0;

  // Advance the model on each rising edge from the inputs sampled there.
  always @(posedge clk) begin
    if (rst) begin
      m_t = 0;
      m_valid = 1'b1;
    end else if (m_t == 0) begin
      if (ipgu_out_ready) m_t = 1;
    end else if (m_t >= T_D) begin
      if (rdn_in_ready) m_t = 0;
    end else begin
      m_t = m_t + 1;
    end
  end

  int hist_cnt = 0, cdf_cnt = 0, map_cnt = 0, load_cnt = 0, out_cnt = 0;

  // Compare every output against the timeline model, mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      int t;
      bit e_h, e_c, e_m;
      t   = m_t;
      e_h = (t >= T_H0) && (t < T_C0);
      e_c = (t >= T_C0) && (t < T_M0);
      e_m = (t >= T_M0) && (t < T_D);
      chk("in_ready",  int'(in_ready),  int'(t == 0));
      chk("out_ready", int'(out_ready), int'(t >= T_D));
      chk("load_en",   int'(load_en),   int'((t == 0) && ipgu_out_ready));
      chk("hist_clr",  int'(hist_clr),  int'(t == 1));
      chk("hist_en",   int'(hist_en),   int'(e_h));
      chk("hist_row",  int'(hist_row),  e_h ? (t - T_H0) / NSEG : 0);
      chk("hist_seg",  int'(hist_seg),  e_h ? (t - T_H0) % NSEG : 0);
      chk("cdf_en",    int'(cdf_en),    int'(e_c));
      chk("cdf_bin",   int'(cdf_bin),   e_c ? t - T_C0 : 0);
      chk("cdf_first", int'(cdf_first), int'(t == T_C0));
      chk("map_en",    int'(map_en),    int'(e_m));
      chk("map_row",   int'(map_row),   e_m ? t - T_M0 : 0);
      chk("busy",      int'(busy),      int'(t != 0));
      chk("rdy_excl",  int'(in_ready & out_ready), 0);
      chk("en_excl",   int'((int'(hist_clr) + int'(hist_en) + int'(cdf_en) + int'(map_en)) <= 1), 1);
      // Independent phase bookkeeping from the DUT's own strobes.
      if (hist_clr) begin
        hist_cnt = 0; cdf_cnt = 0; map_cnt = 0;
      end
      if (hist_en) begin
        chk("hist_order", int'(hist_row) * NSEG + int'(hist_seg), hist_cnt);
        hist_cnt++;
      end
      if (cdf_en) cdf_cnt++;
      if (map_en) begin
        map_cnt++;
        if (int'(map_row) == ROWS - 1) begin
          chk("hist_cycles", hist_cnt, 25);
          chk("cdf_cycles",  cdf_cnt,  256);
          chk("map_cycles",  map_cnt,  5);
        end
      end
      if (load_en) load_cnt++;
      if (out_ready) out_cnt++;
    end
  end

  // Count negedges from the current edge until out_ready shows; bounded.
  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (out_ready) break;
    end
    if (!out_ready) chk("out_timeout", 0, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; ipgu_out_ready = 1'b0; rdn_in_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bin", int'(cdf_bin), 0);
    tick();

    // Single frame: one-cycle request, latency to out_ready.
    ipgu_out_ready = 1'b1;
    @(posedge clk); #1;
    ipgu_out_ready = 1'b0;
    wait_out(n);
    chk("latency", n, 288);
    tick();

    // Release after holding the result 10 cycles.
    repeat (10) tick();
    chk("held_out", int'(out_ready), 1);
    rdn_in_ready = 1'b1;
    tick();
    rdn_in_ready = 1'b0;
    @(negedge clk);
    chk("rel_out", int'(out_ready), 0);
    chk("rel_in", int'(in_ready), 1);
    tick();

    // RDN always ready: result visible exactly one cycle.
    out_cnt = 0;
    rdn_in_ready = 1'b1;
    ipgu_out_ready = 1'b1;
    tick();
    ipgu_out_ready = 1'b0;
    repeat (300) tick();
    chk("tied_out_cycles", out_cnt, 1);
    rdn_in_ready = 1'b0;

    // Request held through a frame: only the IDLE cycles produce load_en.
    load_cnt = 0;
    ipgu_out_ready = 1'b1;
    tick();
    wait_out(n);
    chk("latency2", n, 288);
    chk("held_req_loads", load_cnt, 1);
    tick();
    rdn_in_ready = 1'b1;
    tick();
    rdn_in_ready = 1'b0;
    @(negedge clk);
    chk("reaccept_load", int'(load_en), 1);
    tick();
    ipgu_out_ready = 1'b0;
    chk("held_req_loads2", load_cnt, 2);

    // Mid-frame reset at cdf_bin 100 abandons the frame.
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cdf_en && int'(cdf_bin) == 100) break;
      n++;
    end
    chk("reach_bin100", int'(cdf_en && int'(cdf_bin) == 100), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_in_ready", int'(in_ready), 1);
    chk("mrst_busy", int'(busy), 0);
    out_cnt = 0;
    repeat (300) tick();
    chk("mrst_no_out", out_cnt, 0);

    // Next frame after the abandoned one still runs the full latency.
    ipgu_out_ready = 1'b1;
    @(posedge clk); #1;
    ipgu_out_ready = 1'b0;
    wait_out(n);
    chk("latency3", n, 288);
    tick();
    rdn_in_ready = 1'b1;
    tick();
    rdn_in_ready = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
